// File: rtl/axi_lite_master_pkg.sv
// Shared types and constants for the AXI-Lite command master.
package axi_lite_master_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 32;

  // Response codes returned on the local response port.
  localparam logic [3:0] RESP_OKAY    = 4'd3;
  localparam logic [3:0] RESP_TIMEOUT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  // States in which the master waits on the slave and the watchdog runs.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_RD_ADDR) || (s == ST_RD_DATA) ||
           (s == ST_WR_REQ)  || (s == ST_WR_RESP);
  endfunction

endpackage

// File: rtl/axi_timeout_ctr.sv
// 8-bit watchdog counter: counts enabled cycles, flags the last allowed one.
module axi_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [7:0] r_cnt;

  // Count cycles spent in the current wait state; clear restarts the window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Asserted during the LIMIT-th cycle, so the state is left after LIMIT cycles.
  assign o_expired = i_enable && (r_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master driven by a local command/response port.
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  m_clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [3:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] read_address,
  output logic                  AR_VALID,
  input  logic                  AR_READY,
  input  logic [DATA_WIDTH-1:0] data_read,
  input  logic                  R_VALID,
  output logic                  R_READY,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic                  AW_VALID,
  input  logic                  AW_READY,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  W_VALID,
  input  logic                  W_READY,
  input  logic                  B_VALID,
  input  logic [3:0]            BRESPONSE,
  output logic                  B_READY
);

  state_t                r_state;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [3:0]            r_rsp_resp;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arvalid;
  logic                  r_rready;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_awvalid;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_aw_done;
  logic                  r_w_done;

  logic w_ar_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_wr_both;
  logic w_advance;
  logic w_tmo_en;
  logic w_tmo_clr;
  logic w_expired;
  logic w_abort;

  assign w_ar_hs   = r_arvalid && AR_READY;
  assign w_aw_hs   = r_awvalid && AW_READY;
  assign w_w_hs    = r_wvalid && W_READY;
  // Both write channels finished, counting handshakes landing this cycle.
  assign w_wr_both = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  // The current wait state completes this cycle; completion beats a timeout.
  assign w_advance = ((r_state == ST_RD_ADDR) && w_ar_hs)   ||
                     ((r_state == ST_RD_DATA) && R_VALID)   ||
                     ((r_state == ST_WR_REQ)  && w_wr_both) ||
                     ((r_state == ST_WR_RESP) && B_VALID);

  assign w_tmo_en  = is_wait_state(r_state);
  assign w_tmo_clr = !w_tmo_en || w_advance;
  assign w_abort   = w_expired && !w_advance;

  axi_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .i_clk     (m_clk),
    .i_rst_n   (rst),
    .i_clear   (w_tmo_clr),
    .i_enable  (w_tmo_en),
    .o_expired (w_expired)
  );

  // Transaction sequencer with all channel and response outputs registered.
  always_ff @(posedge m_clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= ST_WR_REQ;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (R_VALID) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= data_read;
            r_rsp_resp  <= RESP_OKAY;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
          end
        end
        ST_WR_REQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_wr_both) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (B_VALID) begin
            r_bready    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= BRESPONSE;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Watchdog abort overrides the state's own updates.
      if (w_abort) begin
        r_arvalid   <= 1'b0;
        r_rready    <= 1'b0;
        r_awvalid   <= 1'b0;
        r_wvalid    <= 1'b0;
        r_bready    <= 1'b0;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= RESP_TIMEOUT;
        r_rsp_valid <= 1'b1;
        r_state     <= ST_RSP;
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign read_address  = r_araddr;
  assign AR_VALID      = r_arvalid;
  assign R_READY       = r_rready;
  assign write_address = r_awaddr;
  assign AW_VALID      = r_awvalid;
  assign write_data    = r_wdata;
  assign W_VALID       = r_wvalid;
  assign B_READY       = r_bready;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: slave memory stub plus response scoreboard.
module tb_axi_lite_master;
  import axi_lite_master_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          m_clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [3:0]    rsp_resp;
  logic [AW-1:0] read_address;
  logic          AR_VALID;
  logic          AR_READY;
  logic [DW-1:0] data_read;
  logic          R_VALID;
  logic          R_READY;
  logic [AW-1:0] write_address;
  logic          AW_VALID;
  logic          AW_READY;
  logic [DW-1:0] write_data;
  logic          W_VALID;
  logic          W_READY;
  logic          B_VALID;
  logic [3:0]    BRESPONSE;
  logic          B_READY;

  always #5 m_clk = ~m_clk;

  axi_lite_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .m_clk         (m_clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .read_address  (read_address),
    .AR_VALID      (AR_VALID),
    .AR_READY      (AR_READY),
    .data_read     (data_read),
    .R_VALID       (R_VALID),
    .R_READY       (R_READY),
    .write_address (write_address),
    .AW_VALID      (AW_VALID),
    .AW_READY      (AW_READY),
    .write_data    (write_data),
    .W_VALID       (W_VALID),
    .W_READY       (W_READY),
    .B_VALID       (B_VALID),
    .BRESPONSE     (BRESPONSE),
    .B_READY       (B_READY)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Slave stub controls, driven only by the main sequence.
  logic       s_ar_block;
  logic       s_b_block;
  int         s_aw_hold;
  logic [3:0] s_bresp;

  logic [DW-1:0] smem [256];
  logic          s_rvalid;
  logic [DW-1:0] s_rdata;
  logic          s_bvalid;
  logic          s_got_aw;
  logic          s_got_w;
  logic [AW-1:0] s_awaddr;
  logic [DW-1:0] s_wdata;
  int            s_aw_vcyc;

  assign AR_READY  = !s_ar_block;
  assign AW_READY  = (s_aw_vcyc >= s_aw_hold);
  assign W_READY   = 1'b1;
  assign R_VALID   = s_rvalid;
  assign data_read = s_rdata;
  assign B_VALID   = s_bvalid;
  assign BRESPONSE = s_bresp;

  function automatic logic [DW-1:0] init_val(input int a);
    return 32'(a % 16) * 32'h11;
  endfunction

  // Slave memory: read data one cycle after AR, B one cycle after both write halves.
  always @(posedge m_clk or negedge rst) begin
    if (!rst) begin
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_bvalid  <= 1'b0;
      s_got_aw  <= 1'b0;
      s_got_w   <= 1'b0;
      s_awaddr  <= '0;
      s_wdata   <= '0;
      s_aw_vcyc <= 0;
      for (int i = 0; i < 256; i++) smem[i] <= init_val(i);
    end else begin
      s_aw_vcyc <= AW_VALID ? s_aw_vcyc + 1 : 0;
      if (AR_VALID && AR_READY) begin
        s_rvalid <= 1'b1;
        s_rdata  <= smem[read_address];
      end else if (s_rvalid && R_READY) begin
        s_rvalid <= 1'b0;
      end
      if (AW_VALID && AW_READY) begin
        s_got_aw <= 1'b1;
        s_awaddr <= write_address;
      end
      if (W_VALID && W_READY) begin
        s_got_w <= 1'b1;
        s_wdata <= write_data;
      end
      if (s_got_aw && s_got_w && !s_b_block) begin
        smem[s_awaddr] <= s_wdata;
        s_bvalid       <= 1'b1;
        s_got_aw       <= 1'b0;
        s_got_w        <= 1'b0;
      end
      if (s_bvalid && B_READY) s_bvalid <= 1'b0;
    end
  end

  typedef struct {
    logic [DW-1:0] rdata;
    logic [3:0]    resp;
  } exp_t;
  exp_t sb_q[$];

  int cyc = 0;
  int ar_cyc = 0, aw_cyc = 0, w_cyc = 0, b_hs = 0, rsp_cyc = 0;

  always @(posedge m_clk) cyc <= cyc + 1;

  // Scoreboard monitor: pops on each response handshake, tallies channel activity.
  always @(negedge m_clk) begin
    if (rst) begin
      if (AR_VALID) ar_cyc <= ar_cyc + 1;
      if (AW_VALID) aw_cyc <= aw_cyc + 1;
      if (W_VALID) w_cyc <= w_cyc + 1;
      if (B_VALID && B_READY) b_hs <= b_hs + 1;
      if (rsp_valid) rsp_cyc <= rsp_cyc + 1;
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
        end
      end
    end
  end

  logic [DW-1:0] exp_mem [256];

  // Offer one command and return right after its handshake edge.
  task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit push, input logic [DW-1:0] er, input logic [3:0] eresp);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    @(negedge m_clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int k = 0; k < 50; k++) begin
      if (cmd_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge m_clk);
    end
    if (!seen) begin
      chk("cmd_accept", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge m_clk);
    #1;
    cmd_valid = 1'b0;
    if (push) begin
      e.rdata = er;
      e.resp  = eresp;
      sb_q.push_back(e);
    end
  endtask

  // Wait for rsp_valid and check in which cycle after the handshake it appears.
  task automatic wait_rsp(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge m_clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk(tag, 32'(lat), 32'(exp_lat));
  endtask

  int snap_ar, snap_aw, snap_w, snap_b, snap_rsp;
  logic [DW-1:0] held;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b1;
    s_ar_block = 1'b0;
    s_b_block  = 1'b0;
    s_aw_hold  = 0;
    s_bresp    = RESP_OKAY;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    rst = 1'b0;

    // Reset state
    repeat (3) @(posedge m_clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_valid_ready", 32'({AR_VALID, AW_VALID, W_VALID, R_READY, B_READY, rsp_valid}), 32'd0);
    chk("rst_addr", 32'({read_address, write_address}), 32'd0);
    chk("rst_data", write_data | rsp_rdata, 32'd0);
    chk("rst_resp", 32'(rsp_resp), 32'd0);
    @(negedge m_clk);
    rst = 1'b1;
    @(posedge m_clk);
    #1;
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Plain read
    send(1'b0, 8'h05, '0, 1'b1, exp_mem[5], RESP_OKAY);
    wait_rsp("rd_lat", 3);
    @(negedge m_clk);
    chk("b2b_ready", 32'(cmd_ready), 32'd1);

    // Write then read back
    exp_mem[2] = 32'hA5;
    send(1'b1, 8'h02, 32'hA5, 1'b1, '0, RESP_OKAY);
    wait_rsp("wr_lat", 4);
    send(1'b0, 8'h02, '0, 1'b1, exp_mem[2], RESP_OKAY);
    wait_rsp("rd2_lat", 3);

    // Slave response code passed through untouched
    s_bresp = 4'd2;
    exp_mem[6] = 32'h3C;
    send(1'b1, 8'h06, 32'h3C, 1'b1, '0, 4'd2);
    wait_rsp("wr_err_lat", 4);
    s_bresp = RESP_OKAY;

    // Split write: AW held off three cycles, W accepted immediately
    @(posedge m_clk);
    #1;
    snap_aw = aw_cyc;
    snap_w  = w_cyc;
    snap_b  = b_hs;
    s_aw_hold = 3;
    exp_mem[9] = 32'h77;
    send(1'b1, 8'h09, 32'h77, 1'b1, '0, RESP_OKAY);
    wait_rsp("split_lat", 7);
    chk("split_w_cycles", 32'(w_cyc - snap_w), 32'd1);
    chk("split_aw_cycles", 32'(aw_cyc - snap_aw), 32'd4);
    chk("split_b_hs", 32'(b_hs - snap_b), 32'd1);
    s_aw_hold = 0;
    send(1'b0, 8'h09, '0, 1'b1, exp_mem[9], RESP_OKAY);
    wait_rsp("split_rd_lat", 3);

    // Timeout: AR never accepted
    @(posedge m_clk);
    #1;
    snap_ar = ar_cyc;
    s_ar_block = 1'b1;
    send(1'b0, 8'h03, '0, 1'b1, '0, RESP_TIMEOUT);
    wait_rsp("tmo_lat", 17);
    chk("tmo_ar_cycles", 32'(ar_cyc - snap_ar), 32'd16);
    chk("tmo_ar_dropped", 32'(AR_VALID), 32'd0);
    s_ar_block = 1'b0;

    // Backpressure on the response port
    @(posedge m_clk);
    #1;
    rsp_ready = 1'b0;
    send(1'b0, 8'h02, '0, 1'b1, exp_mem[2], RESP_OKAY);
    wait_rsp("bp_lat", 3);
    held = rsp_rdata;
    chk("bp_first_data", held, exp_mem[2]);
    for (int k = 0; k < 5; k++) begin
      @(negedge m_clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata_stable", rsp_rdata, held);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge m_clk);
    #1;
    rsp_ready = 1'b1;
    repeat (2) @(negedge m_clk);

    // Reset during WR_RESP: no B from the slave, then asynchronous reset
    s_b_block = 1'b1;
    send(1'b1, 8'h04, 32'h33, 1'b0, '0, RESP_OKAY);
    for (int k = 0; k < 10; k++) begin
      if (B_READY) break;
      @(negedge m_clk);
    end
    chk("wr_resp_reached", 32'(B_READY), 32'd1);
    repeat (2) @(negedge m_clk);
    @(posedge m_clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_outs", 32'({AR_VALID, AW_VALID, W_VALID, R_READY, B_READY, rsp_valid}), 32'd0);
    chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    @(negedge m_clk);
    s_b_block = 1'b0;
    rst = 1'b1;
    snap_rsp = rsp_cyc;
    @(posedge m_clk);
    #1;
    chk("post_rst_idle", 32'(cmd_ready), 32'd1);
    repeat (5) @(negedge m_clk);
    chk("post_rst_no_rsp", 32'(rsp_cyc - snap_rsp), 32'd0);

    // Normal operation after reset
    send(1'b0, 8'h05, '0, 1'b1, exp_mem[5], RESP_OKAY);
    wait_rsp("post_rst_rd_lat", 3);
    repeat (3) @(negedge m_clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI-Lite master that turns single-beat commands from a local command port into AXI-Lite read and write transactions. It drives the slave memory block's AR/R/AW/W/B channels directly and returns read data and write responses on a local response port. It handles one outstanding transaction at a time. A timeout counter guarantees that every accepted command produces a response.

## Interface
Parameters:
- ADDR_WIDTH, default `ADDR_WIDTH (from axi_params.vh): width of the address fields.
- DATA_WIDTH, default `DATA_WIDTH (from axi_params.vh): width of the data fields.
- TIMEOUT_CYCLES, default 16: cycles allowed in any wait state before the transaction is aborted. Legal range 2..255.

Ports:
- m_clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; one clock, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  4  BRESPONSE for writes, RESP_OKAY for successful reads, RESP_TIMEOUT on abort.
- read_address  out  ADDR_WIDTH, AR_VALID out 1, AR_READY in 1: read address channel.
- data_read  in  DATA_WIDTH, R_VALID in 1, R_READY out 1: read data channel.
- write_address  out  ADDR_WIDTH, AW_VALID out 1, AW_READY in 1: write address channel.
- write_data  out  DATA_WIDTH, W_VALID out 1, W_READY in 1: write data channel.
- B_VALID  in  1, BRESPONSE in 4, B_READY out 1: write response channel.

## Operation
States:
- IDLE
- RD_ADDR
- RD_DATA
- WR_REQ
- WR_RESP
- RSP

Transitions:
- IDLE:
  - cmd_ready=1.
  - A command handshake latches addr, wdata and the write flag.
  - Next state is WR_REQ for a write, RD_ADDR for a read.
- RD_ADDR:
  - AR_VALID=1 and read_address held stable until AR_VALID&&AR_READY.
  - Then go to RD_DATA.
- RD_DATA:
  - R_READY=1.
  - On R_VALID, capture data_read, set rsp_resp=RESP_OKAY, go to RSP.
- WR_REQ:
  - AW_VALID and W_VALID both asserted.
  - Each channel tracks its own handshake with a done flag and drops its VALID after its own handshake.
  - When both done flags are set, go to WR_RESP. This also covers both handshakes landing in the same cycle.
- WR_RESP:
  - B_READY=1.
  - On B_VALID, capture BRESPONSE unmodified, go to RSP.
- RSP:
  - rsp_valid=1; outputs held stable.
  - On rsp_ready, go to IDLE.

Timeout:
- The counter clears on entry to RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
- The counter increments every cycle spent in those states.
- When it reaches TIMEOUT_CYCLES:
  - drop all VALID/READY outputs;
  - set rsp_resp=RESP_TIMEOUT and rsp_rdata=0;
  - go to RSP.

Other rules:
- No new command is accepted while a response is pending.
- VALID outputs never deassert before their handshake, except on timeout or reset.

## Timing
- Reset (rst=0), all outputs:
  - state=IDLE;
  - cmd_ready=0 during reset, 1 from the first clock after release;
  - AR_VALID, AW_VALID, W_VALID, R_READY, B_READY, rsp_valid all 0;
  - read_address, write_address, write_data, rsp_rdata all 0;
  - rsp_resp=0.
- Reset asserted mid-transaction: the transaction is abandoned immediately and asynchronously. No response is produced.
- Read latency against the slave, cycle numbers after the command handshake edge:
  - AR_VALID in cycle 1;
  - R_VALID seen in cycle 2;
  - rsp_valid in cycle 3.
- Write latency against the slave:
  - AW_VALID/W_VALID in cycle 1;
  - B_VALID in cycle 3;
  - rsp_valid in cycle 4.
- A back-to-back command is accepted in the cycle after the rsp_ready handshake.
- All AXI outputs are registered; there is no combinational path from AXI inputs to AXI outputs.

## Structure
- Extend the shared header axi_params.vh with:
  - state encodings ST_IDLE..ST_RSP, 3 bits;
  - RESP_OKAY=4'd3, matching the slave's OKAY code;
  - RESP_TIMEOUT=4'hF.
- Sub-module axi_timeout_ctr, 8 bits. Ports: clear and enable in, expired out.

## Test plan
- Read: after slave reset, read addr 0x5 -> rsp_rdata=0x55, rsp_resp=3, rsp_valid in cycle 3.
- Write then read: write 0xA5 to addr 0x2, then read 0x2. Write -> rsp_resp=3 in cycle 4. Read -> rsp_rdata=0xA5.
- Split write: a stub holds AW_READY=0 for 3 cycles while W_READY=1. W_VALID drops after 1 cycle, AW_VALID stays high until its handshake. Then a single B handshake and rsp_resp=3.
- Timeout: a stub never asserts AR_READY -> after 16 cycles AR_VALID=0, rsp_resp=0xF, rsp_rdata=0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0 throughout.
- Reset mid-write during WR_RESP -> all VALID/READY outputs 0 asynchronously, no rsp_valid, IDLE after release.
